// File: rtl/unidade_controle_jogo_pkg.sv
// Shared state codes, output bundle and timer-width helper for the memory-game control unit.
package unidade_controle_jogo_pkg;

    localparam int ESTADO_W_PADRAO = 4;

    // Encodings double as the hex-display code shown on db_estado
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_E;
        logic conta_E;
        logic zera_R;
        logic conta_R;
        logic registra_R;
        logic acertou;
        logic errou;
        logic pronto;
        logic db_timeout;
    } saidas_t;

    function automatic int largura_timer(input int ciclos);
        return (ciclos < 2) ? 1 : $clog2(ciclos);
    endfunction

    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            PREPARA:        begin s.zera_E = 1'b1; s.zera_R = 1'b1; end
            INICIA_RODADA:  s.zera_E = 1'b1;
            REGISTRA:       s.registra_R = 1'b1;
            PROXIMA_JOGADA: s.conta_E = 1'b1;
            PROXIMA_RODADA: s.conta_R = 1'b1;
            FIM_ACERTO:     begin s.pronto = 1'b1; s.acertou = 1'b1; end
            FIM_ERRO:       begin s.pronto = 1'b1; s.errou = 1'b1; end
            FIM_TIMEOUT:    begin s.pronto = 1'b1; s.errou = 1'b1; s.db_timeout = 1'b1; end
            default:        s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game datapath (master) and the control unit (slave).
interface unidade_controle_jogo_if #(
    parameter int ESTADO_W = 4
);
    logic iniciar;
    logic jogada;
    logic igual;
    logic fim_E;
    logic fim_R;
    logic zera_E;
    logic conta_E;
    logic zera_R;
    logic conta_R;
    logic registra_R;
    logic acertou;
    logic errou;
    logic pronto;
    logic db_timeout;
    logic [ESTADO_W-1:0] db_estado;

    modport master (
        output iniciar, jogada, igual, fim_E, fim_R,
        input  zera_E, conta_E, zera_R, conta_R, registra_R,
        input  acertou, errou, pronto, db_timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, fim_E, fim_R,
        output zera_E, conta_E, zera_R, conta_R, registra_R,
        output acertou, errou, pronto, db_timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-play timeout counter: counts while enabled, saturates on its last value and flags it.
module contador_timeout
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = largura_timer(TIMEOUT_CYCLES);
    localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] contagem_q;

    // Saturating so a long wait never wraps back and hides an expiry
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem_q <= '0;
        end else if (conta && (contagem_q != ULTIMO)) begin
            contagem_q <= contagem_q + W'(1);
        end
    end

    assign fim = (contagem_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game; per-play timeout built only with CONTROLE_TIMEOUT_EN.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3000,
    parameter int ESTADO_W       = ESTADO_W_PADRAO
) (
    input logic              clock,
    input logic              reset,
    unidade_controle_jogo_if.slave bus
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_invalido
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    estado_t             estado_q, estado_d;
    saidas_t             saidas_q;
    logic [ESTADO_W-1:0] db_estado_q;
    logic                timer_fim;

`ifdef CONTROLE_TIMEOUT_EN
    localparam bit TIMEOUT_HABILITADO = 1'b1;

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  ((estado_q == INICIA_RODADA) || (estado_q == PROXIMA_JOGADA)),
        .conta (estado_q == ESPERA_JOGADA),
        .fim   (timer_fim)
    );
`else
    localparam bit TIMEOUT_HABILITADO = 1'b0;

    assign timer_fim = 1'b0;
`endif

    // A play arriving on the expiry cycle takes precedence over the timeout
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (bus.iniciar) estado_d = PREPARA;
            PREPARA:        estado_d = INICIA_RODADA;
            INICIA_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (bus.jogada)     estado_d = REGISTRA;
                else if (timer_fim) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!bus.igual)                   estado_d = FIM_ERRO;
                else if (bus.fim_E && bus.fim_R)  estado_d = FIM_ACERTO;
                else if (bus.fim_E)               estado_d = PROXIMA_RODADA;
                else                              estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (bus.iniciar) estado_d = PREPARA;
            end
            default:        estado_d = INICIAL;
        endcase
    end

    // Outputs are registered from the next state so they always equal the decode of estado_q
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INICIAL;
            saidas_q    <= '0;
            db_estado_q <= '0;
        end else begin
            estado_q    <= estado_d;
            saidas_q    <= decodifica(estado_d);
            db_estado_q <= ESTADO_W'(estado_d);
        end
    end

    assign bus.zera_E     = saidas_q.zera_E;
    assign bus.conta_E    = saidas_q.conta_E;
    assign bus.zera_R     = saidas_q.zera_R;
    assign bus.conta_R    = saidas_q.conta_R;
    assign bus.registra_R = saidas_q.registra_R;
    assign bus.acertou    = saidas_q.acertou;
    assign bus.errou      = saidas_q.errou;
    assign bus.pronto     = saidas_q.pronto;
    assign bus.db_timeout = saidas_q.db_timeout & TIMEOUT_HABILITADO;
    assign bus.db_estado  = db_estado_q;

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore FSM that sequences the memory-game datapath used with circuito_exp4_desafio. It handles the game start, the growing rounds (round r requires plays 0..r), per-play registration and comparison, round/end-of-game detection and the per-play timeout. The datapath holds the address counter (E), round counter (R), play register, memory and comparator. This block drives their control strobes and the user-visible result flags.

Parameters:
TIMEOUT_CYCLES, 3000, clock cycles allowed per play in ESPERA_JOGADA (3 s at 1 kHz); must be >=2
ESTADO_W, 4, width of db_estado (hex-display code)

Ports:
clock       in   1  system clock, rising edge
reset       in   1  synchronous, active-high
iniciar     in   1  start request, level
jogada      in   1  one-cycle pulse from datapath edge detector (tem_jogada)
igual       in   1  comparator: registered play == memory word
fim_E       in   1  address counter == round counter
fim_R       in   1  round counter == last round
zera_E      out  1  clear address counter
conta_E     out  1  increment address counter
zera_R      out  1  clear round counter
conta_R     out  1  increment round counter
registra_R  out  1  load play register from chaves
acertou     out  1  game won
errou       out  1  game lost (mismatch or timeout)
pronto      out  1  game finished
db_timeout  out  1  lost by timeout
db_estado   out  ESTADO_W  current state code

Behaviour:
- One clock. Reset is synchronous and active-high. When reset=1 at a rising edge, the state becomes INICIAL and the timer clears, regardless of the current state. This includes mid-round.
- All outputs are Moore decodes of the state register. The only exception is db_timeout, which is also derived from the state. In INICIAL every output is 0 and db_estado=0x0.
- States (code), outputs, and next state:
  - INICIAL (0x0): no outputs. Goes to PREPARA when iniciar=1.
  - PREPARA (0x1): zera_E=1, zera_R=1. Goes to INICIA_RODADA.
  - INICIA_RODADA (0x2): zera_E=1, timer cleared. Goes to ESPERA_JOGADA.
  - ESPERA_JOGADA (0x3): timer counts. Goes to REGISTRA when jogada=1. Goes to FIM_TIMEOUT when the timer reaches TIMEOUT_CYCLES-1 and jogada=0. Otherwise it stays.
  - REGISTRA (0x4): registra_R=1. Goes to COMPARA.
  - COMPARA (0x5): routing, in priority order:
    - igual=0: FIM_ERRO
    - fim_E&fim_R: FIM_ACERTO
    - fim_E: PROXIMA_RODADA
    - otherwise: PROXIMA_JOGADA
  - PROXIMA_JOGADA (0x6): conta_E=1, timer cleared. Goes to ESPERA_JOGADA.
  - PROXIMA_RODADA (0x7): conta_R=1. Goes to INICIA_RODADA.
  - FIM_ACERTO (0xA): pronto=1, acertou=1.
  - FIM_ERRO (0xE): pronto=1, errou=1.
  - FIM_TIMEOUT (0xD): pronto=1, errou=1, db_timeout=1.
  - All three FIM states go to PREPARA when iniciar=1 and otherwise hold.
- Unused codes go to INICIAL.
- iniciar is ignored in all states except INICIAL and the FIM states. jogada is ignored outside ESPERA_JOGADA.
- If jogada and timer expiry occur in the same cycle, jogada wins.
- Timer behaviour:
  - Counter width is $clog2(TIMEOUT_CYCLES).
  - It increments only in ESPERA_JOGADA and saturates at TIMEOUT_CYCLES-1.
  - It clears in INICIA_RODADA, PROXIMA_JOGADA and on reset.
- Latency from a jogada pulse to the result:
  - REGISTRA on the next edge, then COMPARA.
  - On the third edge after the pulse: the FIM state, or PROXIMA_*.
- Game length is set by the datapath fim_R. The block has no built-in round count.

Optional Feature:
CONTROLE_TIMEOUT_EN
- Defined: timer present; the ESPERA_JOGADA→FIM_TIMEOUT transition and db_timeout behave as above.
- Undefined: no timer logic; ESPERA_JOGADA waits indefinitely; FIM_TIMEOUT is unreachable; db_timeout is tied to 0.

Decomposition:
- Shared package/include: state code localparams (ESTADO_W-wide), plus a helper for the timer width.
- One natural sub-module: contador_timeout. Its inputs are clock, reset, zera, conta. Its output is fim, asserted when count == TIMEOUT_CYCLES-1. It is instantiated only under CONTROLE_TIMEOUT_EN.

Test Plan:
- reset=1 for 1 cycle, then idle 10 cycles → db_estado=0x0; all control and result outputs 0.
- iniciar=1, then a jogada pulse with igual=1, fim_E=1, fim_R=0 → db_estado follows 0x1, 0x2, 0x3, 0x4, 0x5, 0x7, 0x2; conta_R high for exactly 1 cycle.
- Round 2: first play with igual=1, fim_E=0, then second play with fim_E=1, fim_R=1 → one conta_E pulse; final state 0xA; pronto=1, acertou=1; iniciar then returns to 0x1.
- Play with igual=0 → 0xE, errou=1, acertou=0. Then reset mid-game in ESPERA_JOGADA → 0x0 on the next edge.
- TIMEOUT_CYCLES=20 with CONTROLE_TIMEOUT_EN, no jogada → 0xD exactly 20 cycles after entering 0x3; errou=1, db_timeout=1. A jogada arriving on the 20th cycle goes to 0x4 instead.
- Without CONTROLE_TIMEOUT_EN: hold in 0x3 for 10000 cycles → stays 0x3; db_timeout=0.
